// File: rtl/protocore_pkg.sv
// Shared definitions for the protocore sequencer: opcodes, FSM states,
// instruction field positions and the decoded-instruction bundle.
package protocore_pkg;

  // Instruction word and field layout: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb
  localparam int INSTR_W = 16;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RA_LSB  = 4;
  localparam int RB_LSB  = 0;
  localparam int IMM_LSB = 0;

  // Opcodes 0-7 are ALU operations; op[2:0] is the ALU select
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_BC   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  // Everything the sequencer needs from the instruction register
  typedef struct packed {
    logic       is_alu;
    logic       is_ldi;
    logic       is_halt;
    logic [2:0] alu_op;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] imm8;
  } dec_t;

  // ALU operations occupy the lower half of the opcode space
  function automatic logic op_is_alu(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into control fields,
// instruction class flags and the resolved branch/jump decision.
module instr_decode
  import protocore_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic [INSTR_W-1:0]  ir,
  input  logic                z_flag,
  input  logic                c_flag,
  output dec_t                dec,
  output logic                taken,
  output logic [PC_WIDTH-1:0] target
);

  logic [3:0] op;
  logic       is_jmp;
  logic       is_bz;
  logic       is_bc;

  assign op     = ir[OP_LSB +: 4];
  assign is_jmp = (op == OP_JMP);
  assign is_bz  = (op == OP_BZ);
  assign is_bc  = (op == OP_BC);

  // Field extraction and class flags; NOP opcodes simply match no class
  always_comb begin
    dec         = '0;
    dec.is_alu  = op_is_alu(op);
    dec.is_ldi  = (op == OP_LDI);
    dec.is_halt = (op == OP_HALT);
    dec.alu_op  = op[2:0];
    dec.rd      = ir[RD_LSB +: 4];
    dec.ra      = ir[RA_LSB +: 4];
    dec.rb      = ir[RB_LSB +: 4];
    dec.imm8    = ir[IMM_LSB +: 8];
  end

  // Conditional branches test the flags latched by the last completed ALU op
  assign taken  = is_jmp | (is_bz & z_flag) | (is_bc & c_flag);
  assign target = ir[PC_WIDTH-1:0];

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetch/decode/execute/writeback FSM that fetches
// from a synchronous-read instruction memory and drives datapath controls.
module control_unit
  import protocore_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  input  logic                alu_zero,
  input  logic                alu_carry,
  output logic [3:0]          ra_addr,
  output logic [3:0]          rb_addr,
  output logic [3:0]          write_addr,
  output logic [7:0]          write_data,
  output logic                wb_sel,
  output logic                write_en,
  output logic [2:0]          alu_opcode,
  output logic                busy,
  output logic                halted
);

  state_t               state_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [INSTR_W-1:0]   ir_q;
  logic                 z_q;
  logic                 c_q;
  logic                 busy_q;
  logic                 halted_q;
  logic                 write_en_q;

  dec_t                 dec;
  logic                 taken;
  logic [PC_WIDTH-1:0]  target;
  logic [PC_WIDTH-1:0]  pc_d;
  logic                 ex_or_wb;

  instr_decode #(
    .PC_WIDTH (PC_WIDTH)
  ) u_decode (
    .ir     (ir_q),
    .z_flag (z_q),
    .c_flag (c_q),
    .dec    (dec),
    .taken  (taken),
    .target (target)
  );

  // Sequential successor or redirect; ALU/LDI never redirect, so they get PC+1
  assign pc_d = taken ? target : (pc_q + PC_WIDTH'(1));

  // Sequencer FSM with registered status outputs and write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      write_en_q <= 1'b0;
    end else begin
      write_en_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_q    <= imem_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec.is_alu) begin
            z_q <= alu_zero;
            c_q <= alu_carry;
          end
          if (dec.is_alu || dec.is_ldi) begin
            // Writing instructions defer the PC update to writeback
            state_q    <= ST_WB;
            write_en_q <= 1'b1;
          end else if (dec.is_halt) begin
            // PC stays on the HALT address
            state_q  <= ST_HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= ST_FETCH;
            pc_q    <= pc_d;
          end
        end
        ST_WB: begin
          state_q <= ST_FETCH;
          pc_q    <= pc_d;
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath controls are held from IR across EXEC and WB, zero elsewhere
  assign ex_or_wb   = (state_q == ST_EXEC) || (state_q == ST_WB);
  assign imem_addr  = pc_q;
  assign ra_addr    = ex_or_wb ? dec.ra     : 4'd0;
  assign rb_addr    = ex_or_wb ? dec.rb     : 4'd0;
  assign write_addr = ex_or_wb ? dec.rd     : 4'd0;
  assign write_data = ex_or_wb ? dec.imm8   : 8'd0;
  assign alu_opcode = ex_or_wb ? dec.alu_op : 3'd0;
  assign wb_sel     = ex_or_wb & dec.is_alu;
  assign write_en   = write_en_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule
